// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache miss/refill path.
//  - Set-image bit positions (two ways + LRU bit, 109 bits total)
//  - Tag/word widths, miss mode encodings
//  - Refill FSM state enum
package dcache_pkg;

    localparam int SET_BITS = 109;
    localparam int TAG_W    = 20;
    localparam int WORD_W   = 32;

    // [108]V1 [107]LRU [106]D1 [105:86]T1 [85:54]W1 | [53]V0 [52]D0 [51:32]T0 [31:0]W0
    localparam int V1_B  = 108;
    localparam int LRU_B = 107;
    localparam int D1_B  = 106;
    localparam int T1_HI = 105;
    localparam int T1_LO = 86;
    localparam int W1_HI = 85;
    localparam int W1_LO = 54;
    localparam int V0_B  = 53;
    localparam int D0_B  = 52;
    localparam int T0_HI = 51;
    localparam int T0_LO = 32;
    localparam int W0_HI = 31;
    localparam int W0_LO = 0;

    localparam logic [1:0] MODE_RD   = 2'b01;
    localparam logic [1:0] MODE_WBRD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD,
        ST_RWAIT,
        ST_FILL
    } state_e;

endpackage

// File: rtl/dcache_set_merge.sv
// Combinational victim selection and refilled set-image construction.
//  set_in       in   current set image
//  fill_tag     in   tag of the missing address
//  fill_word    in   word returned by memory
//  victim_dirty out  victim way is valid and dirty (needs writeback)
//  victim_tag   out  victim way tag
//  victim_word  out  victim way data word
//  fill_set     out  set_in with victim way replaced and LRU updated
module dcache_set_merge
    import dcache_pkg::*;
(
    input  logic [SET_BITS-1:0] set_in,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [WORD_W-1:0]   fill_word,
    output logic                victim_dirty,
    output logic [TAG_W-1:0]    victim_tag,
    output logic [WORD_W-1:0]   victim_word,
    output logic [SET_BITS-1:0] fill_set
);

    logic victim_way;

    // Invalid ways are used first; with both valid, LRU=1 names way0 as LRU.
    always_comb begin
        if (!set_in[V0_B])      victim_way = 1'b0;
        else if (!set_in[V1_B]) victim_way = 1'b1;
        else                    victim_way = ~set_in[LRU_B];
    end

    always_comb begin
        fill_set = set_in;
        if (victim_way) begin
            victim_dirty = set_in[V1_B] & set_in[D1_B];
            victim_tag   = set_in[T1_HI:T1_LO];
            victim_word  = set_in[W1_HI:W1_LO];
            fill_set[V1_B]        = 1'b1;
            fill_set[D1_B]        = 1'b0;
            fill_set[T1_HI:T1_LO] = fill_tag;
            fill_set[W1_HI:W1_LO] = fill_word;
            fill_set[LRU_B]       = 1'b1;
        end else begin
            victim_dirty = set_in[V0_B] & set_in[D0_B];
            victim_tag   = set_in[T0_HI:T0_LO];
            victim_word  = set_in[W0_HI:W0_LO];
            fill_set[V0_B]        = 1'b1;
            fill_set[D0_B]        = 1'b0;
            fill_set[T0_HI:T0_LO] = fill_tag;
            fill_set[W0_HI:W0_LO] = fill_word;
            fill_set[LRU_B]       = 1'b0;
        end
    end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss/refill controller. Captures one miss, optionally writes back
// the dirty victim word, reads the missing word and returns the refilled set
// image as a single-cycle fill pulse.
//  CLK, RESET                 clock, async active-low reset
//  miss_valid/mode/addr/set   miss request from the cache compare stage
//  busy                       miss in flight (capture through FILL)
//  fill_valid, fill_line      one-cycle refilled set image
//  err                        one-cycle pulse when a memory handshake times out
//  mem_req_*                  memory request channel (valid/ready)
//  mem_rsp_valid/data         memory read response
module dcache_refill_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = SET_BITS,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              miss_valid,
    input  logic [1:0]        miss_mode,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [LINE_W-1:0] miss_set,
    output logic              busy,
    output logic              fill_valid,
    output logic [LINE_W-1:0] fill_line,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] set_q;
    logic [CNT_W-1:0]  tmo_cnt;

    logic [ADDR_W-1:0] cur_addr;
    logic [LINE_W-1:0] cur_set;
    logic              victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [31:0]       victim_word;
    logic [LINE_W-1:0] fill_set;

    logic capture, load_wb, load_rd, rsp_take, tmo_fire, cnt_clr, cnt_inc;
    logic unused_addr_lo;

    // In IDLE the merge logic looks at the incoming request so the WB/RD
    // decision and the first memory address are ready at the capture edge.
    assign cur_addr = (state_q == ST_IDLE) ? miss_addr : addr_q;
    assign cur_set  = (state_q == ST_IDLE) ? miss_set  : set_q;
    assign unused_addr_lo = ^addr_q[1:0];

    dcache_set_merge u_merge (
        .set_in       (cur_set),
        .fill_tag     (cur_addr[ADDR_W-1 -: TAG_W]),
        .fill_word    (mem_rsp_data),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_word  (victim_word),
        .fill_set     (fill_set)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_wb  = 1'b0;
        load_rd  = 1'b0;
        rsp_take = 1'b0;
        tmo_fire = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_valid && (miss_mode == MODE_RD || miss_mode == MODE_WBRD)) begin
                    capture = 1'b1;
                    cnt_clr = 1'b1;
                    if (miss_mode == MODE_WBRD && victim_dirty) begin
                        load_wb = 1'b1;
                        state_d = ST_WB;
                    end else begin
                        load_rd = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_WB, ST_RD, ST_RWAIT: begin
                if (state_q == ST_RWAIT ? mem_rsp_valid : mem_req_ready) begin
                    cnt_clr  = 1'b1;
                    load_rd  = (state_q == ST_WB);
                    rsp_take = (state_q == ST_RWAIT);
                    state_d  = (state_q == ST_WB) ? ST_RD :
                               (state_q == ST_RD) ? ST_RWAIT : ST_FILL;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_FILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q        <= '0;
            set_q         <= '0;
            tmo_cnt       <= '0;
            fill_line     <= '0;
            err           <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
        end else begin
            if (capture) begin
                addr_q <= miss_addr;
                set_q  <= miss_set;
            end
            // Request fields only change on entry to WB/RD, so they hold
            // steady for as long as the memory stalls.
            if (load_wb) begin
                mem_req_we    <= 1'b1;
                mem_req_addr  <= {victim_tag, cur_addr[11:2], 2'b00};
                mem_req_wdata <= victim_word;
            end else if (load_rd) begin
                mem_req_we    <= 1'b0;
                mem_req_addr  <= {cur_addr[ADDR_W-1:2], 2'b00};
            end
            if (rsp_take) fill_line <= fill_set;
            err <= tmo_fire;
            if (cnt_clr)      tmo_cnt <= '0;
            else if (cnt_inc) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign fill_valid    = (state_q == ST_FILL);
    assign mem_req_valid = (state_q == ST_WB) || (state_q == ST_RD);

endmodule
